// File: rtl/conv_line_feeder.sv
// rtl/conv_line_feeder.sv - streams BRAM lines into the convolution engine with gap and repeat windows
module conv_line_feeder #(
  parameter int DATA_W        = 8,
  parameter int LINE_W        = 482,
  parameter int ADDR_W        = 18,
  parameter int GAP_CYCLES    = 20,
  parameter int REPEAT_CYCLES = 3360
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_lines,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] s_data,
  output logic              valid_in,
  output logic              repeat_in
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
  localparam logic [15:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [15:0]       REP_LAST  = 16'(REPEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_GAP, S_REPEAT, S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_num_lines;
  logic [15:0]       r_line;
  logic [COL_W-1:0]  r_col;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_zero;
  logic              r_rd_d1;

  logic              r_busy;
  logic              r_done;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_s_data;
  logic              r_valid_in;
  logic              r_repeat_in;

  logic [15:0] w_line_inc;
  logic        w_line_last;
  logic        w_col_last;
  logic        w_drain_last;
  logic        w_gap_last;
  logic        w_rep_last;

  assign w_line_inc   = r_line + 16'd1;
  assign w_line_last  = (w_line_inc == r_num_lines);
  assign w_col_last   = (r_col == COL_LAST);
  assign w_drain_last = (r_cnt == 16'd1);
  assign w_gap_last   = (r_cnt == GAP_LAST);
  assign w_rep_last   = (r_cnt == REP_LAST);

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign s_data    = r_s_data;
  assign valid_in  = r_valid_in;
  assign repeat_in = r_repeat_in;

  // State register
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a zero-line job lingers one extra cycle in FIN so done lands at cycle 2
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (num_lines == 16'd0) ? S_FIN : S_READ;
      S_READ:   if (w_col_last) w_next = S_DRAIN;
      S_DRAIN:  if (w_drain_last) w_next = (GAP_CYCLES == 0) ? S_REPEAT : S_GAP;
      S_GAP:    if (w_gap_last) w_next = S_REPEAT;
      S_REPEAT: if (w_rep_last) w_next = w_line_last ? S_FIN : S_READ;
      S_FIN:    if (!r_zero) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job parameters, column/line/phase counters and running line base address
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_num_lines <= '0;
      r_line      <= '0;
      r_col       <= '0;
      r_cnt       <= '0;
      r_line_base <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_lines <= num_lines;
            r_line      <= '0;
            r_col       <= '0;
            r_cnt       <= '0;
            r_line_base <= base_addr;
            r_zero      <= (num_lines == 16'd0);
          end
        end
        S_READ: begin
          r_col <= w_col_last ? '0 : r_col + 1'b1;
          r_cnt <= '0;
        end
        S_DRAIN, S_GAP: begin
          r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
        end
        S_REPEAT: begin
          r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
          if (w_rep_last) begin
            r_line      <= w_line_inc;
            r_line_base <= r_line_base + LINE_STEP;
          end
        end
        S_FIN:   r_zero <= 1'b0;
        default: r_cnt  <= '0;
      endcase
    end
  end

  // Registered outputs: control derived from next state, pixel path two stages behind the read
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_rd_d1     <= 1'b0;
      r_s_data    <= '0;
      r_valid_in  <= 1'b0;
      r_repeat_in <= 1'b0;
    end else begin
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_FIN) && (r_state != S_IDLE);
      r_mem_rd_en <= (w_next == S_READ);
      r_repeat_in <= (w_next == S_REPEAT);
      r_rd_d1     <= r_mem_rd_en;
      r_valid_in  <= r_rd_d1;
      r_s_data    <= r_rd_d1 ? mem_rdata : '0;
      if (r_state == S_IDLE && start && num_lines != 16'd0)
        r_mem_addr <= base_addr;
      else if (r_state == S_READ && !w_col_last)
        r_mem_addr <= r_mem_addr + 1'b1;
      else if (r_state == S_REPEAT && w_rep_last)
        r_mem_addr <= r_line_base + LINE_STEP;
    end
  end

endmodule

// File: tb/tb_conv_line_feeder.sv
// tb/tb_conv_line_feeder.sv - directed self-checking bench for conv_line_feeder
module tb_conv_line_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic Rst_n;

  logic       a_start, a_busy, a_done, a_rd, a_valid, a_rep;
  logic [7:0] a_base, a_addr, a_rdata, a_data;
  logic [15:0] a_nl;

  logic       b_start, b_busy, b_done, b_rd, b_valid, b_rep;
  logic [3:0] b_base, b_addr;
  logic [7:0] b_rdata, b_data;
  logic [15:0] b_nl;

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:15];

  int checks = 0;
  int errors = 0;

  logic       rv [0:99];
  logic       rr [0:99];
  logic       rrd [0:99];
  logic       rb [0:99];
  logic       rdn [0:99];
  logic [7:0] rdat [0:99];
  logic [7:0] raddr [0:99];

  conv_line_feeder #(.DATA_W(8), .LINE_W(8), .ADDR_W(8), .GAP_CYCLES(2), .REPEAT_CYCLES(5)) dut_a (
    .clk(clk), .Rst_n(Rst_n), .start(a_start), .base_addr(a_base), .num_lines(a_nl),
    .busy(a_busy), .done(a_done), .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .s_data(a_data), .valid_in(a_valid), .repeat_in(a_rep)
  );

  conv_line_feeder #(.DATA_W(8), .LINE_W(8), .ADDR_W(4), .GAP_CYCLES(0), .REPEAT_CYCLES(5)) dut_b (
    .clk(clk), .Rst_n(Rst_n), .start(b_start), .base_addr(b_base), .num_lines(b_nl),
    .busy(b_busy), .done(b_done), .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .s_data(b_data), .valid_in(b_valid), .repeat_in(b_rep)
  );

  function automatic logic [7:0] bval(input int a);
    return 8'(a * 3 + 7);
  endfunction

  always @(posedge clk) begin
    if (a_rd) a_rdata <= mem_a[a_addr];
    if (b_rd) b_rdata <= mem_b[b_addr];
  end

  task automatic kick(input int sel, input logic [7:0] base, input logic [15:0] nl);
    @(negedge clk);
    if (sel == 0) begin a_base = base; a_nl = nl; a_start = 1'b1; end
    else begin b_base = base[3:0]; b_nl = nl; b_start = 1'b1; end
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic capture(input int sel, input int n, input int inj);
    for (int k = 0; k < 100; k++) begin
      rv[k] = 0; rr[k] = 0; rrd[k] = 0; rb[k] = 0; rdn[k] = 0; rdat[k] = 0; raddr[k] = 0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        rv[k] = a_valid; rr[k] = a_rep; rrd[k] = a_rd; rb[k] = a_busy; rdn[k] = a_done;
        rdat[k] = a_data; raddr[k] = a_addr;
      end else begin
        rv[k] = b_valid; rr[k] = b_rep; rrd[k] = b_rd; rb[k] = b_busy; rdn[k] = b_done;
        rdat[k] = b_data; raddr[k] = {4'd0, b_addr};
      end
      if (k == inj) begin a_start = 1'b1; a_nl = 16'd5; end
      else a_start = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_rd, a_valid, a_rep} !== 5'b0 || a_addr !== 8'd0 || a_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: busy=%b done=%b rd=%b valid=%b rep=%b addr=%0d data=%0d, expected all 0",
               a_busy, a_done, a_rd, a_valid, a_rep, a_addr, a_data);
    end
    checks++;
    if ({b_busy, b_done, b_rd, b_valid, b_rep} !== 5'b0 || b_addr !== 4'd0 || b_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: busy=%b done=%b rd=%b valid=%b rep=%b, expected all 0",
               b_busy, b_done, b_rd, b_valid, b_rep);
    end
    Rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", a_busy, a_done);
    end
  endtask

  task automatic test_basic_line;
    logic ev, er, ed, eb, erd;
    logic [7:0] edat;
    kick(0, 8'd0, 16'd1);
    capture(0, 25, -1);
    for (int k = 1; k <= 25; k++) begin
      ev = (k >= 3 && k <= 10);
      er = (k >= 13 && k <= 17);
      ed = (k == 18);
      eb = (k <= 18);
      erd = (k <= 8);
      edat = ev ? 8'(k - 2) : 8'd0;
      checks++;
      if (rv[k] !== ev || rdat[k] !== edat) begin
        errors++;
        $display("FAIL basic_pixel cyc %0d: valid=%b data=%0d, expected valid=%b data=%0d", k, rv[k], rdat[k], ev, edat);
      end
      checks++;
      if (rr[k] !== er) begin
        errors++;
        $display("FAIL basic_repeat cyc %0d: repeat_in=%b, expected %b", k, rr[k], er);
      end
      checks++;
      if (rdn[k] !== ed || rb[k] !== eb) begin
        errors++;
        $display("FAIL basic_done_busy cyc %0d: done=%b busy=%b, expected done=%b busy=%b", k, rdn[k], rb[k], ed, eb);
      end
      checks++;
      if (rrd[k] !== erd || (erd && raddr[k] !== 8'(k - 1))) begin
        errors++;
        $display("FAIL basic_read cyc %0d: rd_en=%b addr=%0d, expected rd_en=%b addr=%0d", k, rrd[k], raddr[k], erd, k - 1);
      end
    end
  endtask

  task automatic test_multi_line;
    int nrd, nv, nrep, nrise, novl, ndone;
    kick(0, 8'd100, 16'd3);
    capture(0, 60, -1);
    nrd = 0; nv = 0; nrep = 0; nrise = 0; novl = 0; ndone = 0;
    for (int k = 1; k <= 60; k++) begin
      if (rrd[k]) begin
        checks++;
        if (raddr[k] !== 8'(100 + nrd)) begin
          errors++;
          $display("FAIL multi_addr read %0d: addr=%0d, expected %0d", nrd, raddr[k], 100 + nrd);
        end
        nrd++;
      end
      if (rv[k]) begin
        checks++;
        if (rdat[k] !== 8'(101 + nv)) begin
          errors++;
          $display("FAIL multi_data pixel %0d: data=%0d, expected %0d", nv, rdat[k], 101 + nv);
        end
        nv++;
      end
      if (rr[k]) nrep++;
      if (rr[k] && !rr[k-1]) nrise++;
      if (rr[k] && rv[k]) novl++;
      if (rdn[k]) ndone++;
    end
    checks++;
    if (nrd !== 24 || nv !== 24) begin
      errors++;
      $display("FAIL multi_counts: reads=%0d valids=%0d, expected 24 24", nrd, nv);
    end
    checks++;
    if (nrep !== 15 || nrise !== 3 || novl !== 0) begin
      errors++;
      $display("FAIL multi_repeat: cycles=%0d windows=%0d overlap=%0d, expected 15 3 0", nrep, nrise, novl);
    end
    checks++;
    if (rrd[17] !== 1'b0 || rrd[18] !== 1'b1 || rrd[35] !== 1'b1 || rv[20] !== 1'b1 || rv[19] !== 1'b0) begin
      errors++;
      $display("FAIL multi_line_timing: rd17=%b rd18=%b rd35=%b v19=%b v20=%b, expected 0 1 1 0 1",
               rrd[17], rrd[18], rrd[35], rv[19], rv[20]);
    end
    checks++;
    if (rdn[52] !== 1'b1 || ndone !== 1 || rb[53] !== 1'b0) begin
      errors++;
      $display("FAIL multi_done: done52=%b count=%0d busy53=%b, expected 1 1 0", rdn[52], ndone, rb[53]);
    end
  endtask

  task automatic test_addr_wrap_gap0;
    int nrd, nv;
    logic [7:0] ea;
    kick(1, 8'd12, 16'd1);
    capture(1, 22, -1);
    nrd = 0; nv = 0;
    for (int k = 1; k <= 22; k++) begin
      if (rrd[k]) begin
        ea = 8'((12 + nrd) % 16);
        checks++;
        if (raddr[k] !== ea) begin
          errors++;
          $display("FAIL wrap_addr read %0d: addr=%0d, expected %0d", nrd, raddr[k], ea);
        end
        nrd++;
      end
      if (rv[k]) begin
        checks++;
        if (rdat[k] !== bval((12 + nv) % 16)) begin
          errors++;
          $display("FAIL wrap_data pixel %0d: data=%0d, expected %0d", nv, rdat[k], bval((12 + nv) % 16));
        end
        nv++;
      end
      checks++;
      if (rr[k] !== (k >= 11 && k <= 15)) begin
        errors++;
        $display("FAIL gap0_repeat cyc %0d: repeat_in=%b, expected %b", k, rr[k], (k >= 11 && k <= 15));
      end
    end
    checks++;
    if (nrd !== 8 || nv !== 8 || rv[10] !== 1'b1 || rdn[16] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_summary: reads=%0d valids=%0d v10=%b done16=%b, expected 8 8 1 1", nrd, nv, rv[10], rdn[16]);
    end
  endtask

  task automatic test_zero_lines;
    kick(0, 8'd50, 16'd0);
    capture(0, 8, -1);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (rdn[k] !== (k == 2) || rb[k] !== (k <= 2)) begin
        errors++;
        $display("FAIL zero_done_busy cyc %0d: done=%b busy=%b, expected %b %b", k, rdn[k], rb[k], (k == 2), (k <= 2));
      end
      checks++;
      if (rv[k] !== 1'b0 || rr[k] !== 1'b0 || rrd[k] !== 1'b0) begin
        errors++;
        $display("FAIL zero_activity cyc %0d: valid=%b repeat=%b rd=%b, expected 0 0 0", k, rv[k], rr[k], rrd[k]);
      end
    end
  endtask

  task automatic test_busy_start;
    int nv;
    kick(0, 8'd0, 16'd2);
    capture(0, 45, 13);
    nv = 0;
    for (int k = 1; k <= 45; k++) begin
      if (rv[k]) nv++;
      checks++;
      if (rdn[k] !== (k == 35) || rb[k] !== (k <= 35)) begin
        errors++;
        $display("FAIL busy_start cyc %0d: done=%b busy=%b, expected %b %b", k, rdn[k], rb[k], (k == 35), (k <= 35));
      end
    end
    checks++;
    if (nv !== 16) begin
      errors++;
      $display("FAIL busy_start_len: valids=%0d, expected 16", nv);
    end
  endtask

  task automatic test_reset_mid;
    kick(0, 8'd0, 16'd1);
    capture(0, 5, -1);
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_rd, a_valid, a_rep} !== 5'b0 || a_addr !== 8'd0 || a_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b rd=%b valid=%b rep=%b addr=%0d data=%0d, expected all 0",
               a_busy, a_done, a_rd, a_valid, a_rep, a_addr, a_data);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || a_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_hold %0d: done=%b valid=%b, expected 0 0", k, a_done, a_valid);
      end
    end
    Rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic_line();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) mem_b[i] = bval(i);
    Rst_n = 1'b0;
    a_start = 1'b0; a_base = '0; a_nl = '0;
    b_start = 1'b0; b_base = '0; b_nl = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic_line();
    test_multi_line();
    test_addr_wrap_gap0();
    test_zero_lines();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_line_feeder.md
# conv_line_feeder

Streaming source that drives the convolution engine's pixel input port (`s_data`, `valid_in`, `repeat_in`) from the input-feature-map BRAM. On a `start` pulse it reads `num_lines` lines of `LINE_W` pixels each, starting at `base_addr`. After each line it emits a guard gap, then a `repeat_in` window so the engine can replay its buffered line. It sits between the input-map block RAM and `convolution`, replacing bench-generated stimulus in the integrated accelerator.

## Interface
- `DATA_W`, 8, pixel width
- `LINE_W`, 482, pixels per line (≥ 2)
- `ADDR_W`, 18, BRAM address width
- `GAP_CYCLES`, 20, idle cycles between last `valid_in` and first `repeat_in` of a line (≥ 0)
- `REPEAT_CYCLES`, 3360, length of each `repeat_in` window (≥ 1)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `Rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first pixel address; captured with `start`
- `num_lines`  in  16  lines to send; captured with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse at end of job
- `mem_rd_en`  out  1  BRAM read enable
- `mem_addr`  out  ADDR_W  BRAM read address
- `mem_rdata`  in  DATA_W  BRAM data, valid one cycle after `mem_rd_en`
- `s_data`  out  DATA_W  pixel to engine (registered)
- `valid_in`  out  1  pixel valid to engine (registered)
- `repeat_in`  out  1  replay window to engine (registered)

## Operation
- States: IDLE → READ → DRAIN → GAP → REPEAT → (READ | FIN) → IDLE.
- **IDLE**
  - When `start`=1: latch `base_addr` and `num_lines`; clear the column and line counters.
  - If `num_lines`=0, go to FIN. Otherwise go to READ.
- **READ**
  - Assert `mem_rd_en` for LINE_W consecutive cycles.
  - `mem_addr` = base + line·LINE_W + col, computed modulo 2^ADDR_W (wrap allowed, no error).
  - Col counts 0..LINE_W−1.
- **DRAIN**: wait the two pipeline cycles until the last pixel has left `s_data`.
- **GAP**: hold GAP_CYCLES cycles with `valid_in`=`repeat_in`=0. When GAP_CYCLES=0, skip this state.
- **REPEAT**
  - `repeat_in`=1 for exactly REPEAT_CYCLES cycles.
  - Then increment line. If line == num_lines, go to FIN; otherwise go to READ.
- **FIN**: pulse `done`, drop `busy`, return to IDLE.
- Datapath: `s_data` ← `mem_rdata` and `valid_in` ← delayed `mem_rd_en`.
- `s_data` is forced to 0 in every cycle where `valid_in`=0.
- `valid_in` and `repeat_in` are never high in the same cycle.
- `start` asserted while `busy` is ignored.
- Counters: col is ⌈log2 LINE_W⌉ bits; line is 16 bits; gap/repeat counter is 16 bits. Line offset is the product line·LINE_W truncated to ADDR_W.

## Timing
- Reset, asynchronous: all outputs go to 0 (`busy`, `done`, `mem_rd_en`, `mem_addr`, `s_data`, `valid_in`, `repeat_in`), state goes to IDLE, counters clear. Reset mid-job aborts with no `done`.
- Let `start` be sampled at edge 0:
  - `busy`=1 and first `mem_rd_en` at cycle 1.
  - First `valid_in` at cycle 3. This read-to-valid latency is 2 cycles.
- `valid_in` is high for exactly LINE_W contiguous cycles per line, with no bubbles.
- Let the last `valid_in` of a line be at cycle T:
  - `repeat_in` is high over cycles T+GAP_CYCLES+1 … T+GAP_CYCLES+REPEAT_CYCLES.
  - Let R be the last `repeat_in` cycle. The next line's first `mem_rd_en` is at R+1 and its first `valid_in` is at R+3.
  - On the last line, `done`=1 at R+1 and `busy`=0 from R+2.
- For `num_lines`=0: `done` at cycle 2, and `valid_in` and `repeat_in` are never asserted.
- A `start` arriving in the same cycle as `done` is ignored. A new job may start from the cycle after `done`.

## Test plan
- **Basic line** (LINE_W=8, GAP=2, REPEAT=5, base=0, num_lines=1, BRAM[i]=i+1): `s_data` = 1..8 on cycles 3–10 with `valid_in`=1; `repeat_in` on cycles 13–17; `done` at 18.
- **Multi-line addressing** (num_lines=3, base=100, LINE_W=8): `mem_addr` sequences are 100–107, 108–115, 116–123. There are 3 `repeat_in` windows of 5 cycles each, and `valid_in` and `repeat_in` never overlap.
- **Address wrap** (ADDR_W=4, base=12, LINE_W=8): `mem_addr` = 12,13,14,15,0,1,2,3; data order is preserved.
- **Zero lines / GAP=0** (num_lines=0): `done` at cycle 2 with no activity. With GAP=0, `repeat_in` rises the cycle after the last `valid_in`.
- **Busy start**: `start` pulsed mid-REPEAT is ignored; the job length is unchanged and a single `done` is seen.
- **Reset mid-stream**: drop `Rst_n` during READ. All outputs are 0 in the same cycle, with no `done`; after release, a fresh `start` reproduces the basic-line scenario exactly.
